// File: rtl/spi_pkg.sv
// Shared SPI framing constants and state encoding used by the receive and transmit blocks.
package spi_pkg;

   localparam int FRAME_BITS = 16;
   localparam int DATA_BITS  = 12;
   localparam int PAD_BITS   = FRAME_BITS - DATA_BITS;

   typedef enum logic [1:0] {
      WAITING  = 2'd0,
      SHIFTING = 2'd1,
      DONE     = 2'd2
   } spiState_t;

endpackage

// File: rtl/spi_tx_hold_buffer.sv
// One-entry valid/ready holding register between the core and the SPI shifter.
// The shifter empties it with take; a load is only accepted while it is empty.
module spi_tx_hold_buffer
   import spi_pkg::*;
#(
   parameter int dataBits = DATA_BITS
) (
   input  logic                spiClk,
   input  logic                reset,
   input  logic [dataBits-1:0] loadData,
   input  logic                loadValid,
   output logic                loadReady,
   input  logic                take,
   output logic                holdFull,
   output logic [dataBits-1:0] holdData
);

   logic                fullReg;
   logic [dataBits-1:0] dataReg;

   // take only happens while full and a load only while empty, so they never collide
   always_ff @(negedge spiClk or posedge reset) begin
      if (reset) begin
         fullReg <= 1'b0;
         dataReg <= '0;
      end else if (take) begin
         fullReg <= 1'b0;
      end else if (loadValid && !fullReg) begin
         fullReg <= 1'b1;
         dataReg <= loadData;
      end
   end

   assign loadReady = ~fullReg;
   assign holdFull  = fullReg;
   assign holdData  = dataReg;

endmodule

// File: rtl/spi_transmit.sv
// SPI peripheral-mode transmitter: shifts 12-bit result words out MSB first in
// zero-padded 16-bit frames, with a one-word holding buffer ahead of the shifter.
module spi_transmit
   import spi_pkg::*;
#(
   parameter int frameBits = FRAME_BITS,
   parameter int dataBits  = DATA_BITS
) (
   input  logic                spiClk,
   input  logic                reset,
   input  logic                ncs,
   input  logic [dataBits-1:0] readData,
   input  logic                readValid,
   output logic                readReady,
   input  logic                clearUnderrun,
   output logic                sdo,
   output logic                sdoEnable,
   output logic                frameDone,
   output logic                underrun
);

   localparam int countW = $clog2(frameBits);
   localparam logic [countW-1:0] countStart = countW'(frameBits - 2);

   spiState_t                state, stateNext;
   logic [frameBits-1:0]     shiftReg, shiftNext;
   logic [countW-1:0]        bitCounter, counterNext;
   logic                     armed, armedNext;
   logic                     underrunReg, underrunNext;
   logic                     take;
   logic                     holdFull;
   logic [dataBits-1:0]      holdData;
   logic [frameBits-1:0]     holdFrame;

   spi_tx_hold_buffer #(
      .dataBits (dataBits)
   ) holdBuffer (
      .spiClk    (spiClk),
      .reset     (reset),
      .loadData  (readData),
      .loadValid (readValid),
      .loadReady (readReady),
      .take      (take),
      .holdFull  (holdFull),
      .holdData  (holdData)
   );

   assign holdFrame = {holdData, {(frameBits - dataBits){1'b0}}};

   always_ff @(negedge spiClk or posedge reset) begin
      if (reset) begin
         state       <= WAITING;
         shiftReg    <= '0;
         bitCounter  <= countStart;
         armed       <= 1'b0;
         underrunReg <= 1'b0;
      end else begin
         state       <= stateNext;
         shiftReg    <= shiftNext;
         bitCounter  <= counterNext;
         armed       <= armedNext;
         underrunReg <= underrunNext;
      end
   end

   always_comb begin
      stateNext    = state;
      shiftNext    = shiftReg;
      counterNext  = bitCounter;
      armedNext    = armed;
      underrunNext = clearUnderrun ? 1'b0 : underrunReg;
      take         = 1'b0;

      case (state)
         WAITING, DONE: begin
            if (!ncs) begin
               // Start edge; DONE with ncs low is the first shift of a back-to-back frame
               stateNext   = SHIFTING;
               counterNext = countStart;
               if (armed) begin
                  shiftNext = shiftReg << 1;
               end else begin
                  shiftNext    = '0;
                  underrunNext = 1'b1;
               end
            end else begin
               stateNext = WAITING;
               if (!armed && holdFull) begin
                  shiftNext = holdFrame;
                  armedNext = 1'b1;
                  take      = 1'b1;
               end
            end
         end

         SHIFTING: begin
            if (ncs) begin
               // Chip select lost mid-frame: drop the partial word without a frameDone
               stateNext = WAITING;
               shiftNext = '0;
               armedNext = 1'b0;
            end else if (bitCounter != '0) begin
               shiftNext   = shiftReg << 1;
               counterNext = bitCounter - 1'b1;
            end else begin
               stateNext = DONE;
               shiftNext = shiftReg << 1;
               armedNext = 1'b0;
               if (holdFull) begin
                  shiftNext = holdFrame;
                  armedNext = 1'b1;
                  take      = 1'b1;
               end
            end
         end

         default: begin
            stateNext = WAITING;
            shiftNext = '0;
            armedNext = 1'b0;
         end
      endcase
   end

   assign sdo       = ncs ? 1'b0 : shiftReg[frameBits-1];
   assign sdoEnable = ~ncs;
   assign frameDone = (state == DONE);
   assign underrun  = underrunReg;

endmodule

// File: tb/tb_spi_transmit.sv
// Scoreboarded bench for spi_transmit: expected frames are queued as words are pushed
// and compared against the bits sampled on sdo at each rising spiClk edge.
module tb_spi_transmit;
   import spi_pkg::*;

   logic        spiClk = 1'b0;
   logic        reset = 1'b1;
   logic        ncs = 1'b1;
   logic [11:0] readData = '0;
   logic        readValid = 1'b0;
   logic        readReady;
   logic        clearUnderrun = 1'b0;
   logic        sdo;
   logic        sdoEnable;
   logic        frameDone;
   logic        underrun;

   int          nAssert = 0;
   int          nFail = 0;
   int          doneCount = 0;
   logic [15:0] expQ[$];

   spi_transmit dut (
      .spiClk        (spiClk),
      .reset         (reset),
      .ncs           (ncs),
      .readData      (readData),
      .readValid     (readValid),
      .readReady     (readReady),
      .clearUnderrun (clearUnderrun),
      .sdo           (sdo),
      .sdoEnable     (sdoEnable),
      .frameDone     (frameDone),
      .underrun      (underrun)
   );

   always #5 spiClk = ~spiClk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end else begin
         $display("ok   %s: %h", tag, act);
      end
   endtask

   // Monitor: MCU-side sampling on rising edges, one comparison per completed frame
   initial begin
      logic [15:0] bits;
      int          nb;
      logic [15:0] exp;
      bits = '0;
      nb   = 0;
      forever begin
         @(posedge spiClk);
         if (frameDone) doneCount++;
         if (!ncs && !reset) begin
            bits = {bits[14:0], sdo};
            nb++;
            if (nb == 16) begin
               if (expQ.size() == 0) begin
                  check("frame_unexpected", {16'h0, bits}, 32'hffff_ffff);
               end else begin
                  exp = expQ.pop_front();
                  check("frame", {16'h0, bits}, {16'h0, exp});
               end
               nb = 0;
            end
         end else if (nb != 0) begin
            if (expQ.size() != 0) void'(expQ.pop_front());
            nb = 0;
         end
      end
   end

   task automatic push(input logic [11:0] w);
      int t;
      t = 0;
      expQ.push_back({w, 4'h0});
      @(posedge spiClk);
      while (!readReady && t < 200) begin
         @(posedge spiClk);
         t++;
      end
      if (t >= 200) check("push_timeout", {31'h0, readReady}, 32'h1);
      #1;
      readValid = 1'b1;
      readData  = w;
      @(negedge spiClk);
      #1;
      readValid = 1'b0;
   endtask

   task automatic frame(input int n, input bit clr);
      @(negedge spiClk);
      #1;
      ncs           = 1'b0;
      clearUnderrun = clr;
      repeat (n) begin
         @(negedge spiClk);
         #1;
         clearUnderrun = 1'b0;
      end
      ncs = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;

      // Reset state
      repeat (3) @(posedge spiClk);
      #1;
      check("rst_readReady", {31'h0, readReady}, 32'h1);
      check("rst_frameDone", {31'h0, frameDone}, 32'h0);
      check("rst_sdo", {31'h0, sdo}, 32'h0);
      check("rst_sdoEnable", {31'h0, sdoEnable}, 32'h0);
      check("rst_underrun", {31'h0, underrun}, 32'h0);
      reset = 1'b0;

      // Single frame 0xABC
      d0 = doneCount;
      push(12'hABC);
      frame(16, 1'b0);
      repeat (2) @(negedge spiClk);
      #1;
      check("t1_done_pulses", doneCount - d0, 1);
      check("t1_readReady", {31'h0, readReady}, 32'h1);
      check("t1_underrun", {31'h0, underrun}, 32'h0);

      // Back-to-back frames, second word pushed while the first shifts
      d0 = doneCount;
      push(12'h123);
      fork
         frame(32, 1'b0);
         begin
            repeat (4) @(negedge spiClk);
            push(12'hFED);
         end
      join
      repeat (2) @(negedge spiClk);
      #1;
      check("t2_done_pulses", doneCount - d0, 2);
      check("t2_underrun", {31'h0, underrun}, 32'h0);

      // Underrun, set-wins-over-clear, clear alone
      expQ.push_back(16'h0000);
      frame(16, 1'b0);
      #1;
      check("t3_underrun_set", {31'h0, underrun}, 32'h1);
      expQ.push_back(16'h0000);
      frame(16, 1'b1);
      #1;
      check("t3_set_beats_clear", {31'h0, underrun}, 32'h1);
      @(posedge spiClk);
      #1;
      clearUnderrun = 1'b1;
      @(negedge spiClk);
      #1;
      clearUnderrun = 1'b0;
      check("t3_cleared", {31'h0, underrun}, 32'h0);

      // Abort after 7 bits, then a clean frame
      d0 = doneCount;
      push(12'h5A5);
      frame(7, 1'b0);
      repeat (2) @(negedge spiClk);
      #1;
      check("t4_state_waiting", {30'h0, dut.state}, {30'h0, WAITING});
      check("t4_no_done", doneCount - d0, 0);
      d0 = doneCount;
      push(12'h0F0);
      frame(16, 1'b0);
      repeat (2) @(negedge spiClk);
      #1;
      check("t4_done_pulses", doneCount - d0, 1);

      // Back-pressure while the holding buffer is full
      d0 = doneCount;
      push(12'h321);
      push(12'h456);
      @(negedge spiClk);
      #1;
      ncs       = 1'b0;
      readValid = 1'b1;
      readData  = 12'h777;
      expQ.push_back(16'h7770);
      for (int e = 1; e <= 32; e++) begin
         @(negedge spiClk);
         #1;
         if (e == 8) check("t5_ready_low_mid", {31'h0, readReady}, 32'h0);
         if (e == 15) check("t5_ready_low_pre_final", {31'h0, readReady}, 32'h0);
         if (e == 16) check("t5_ready_after_final", {31'h0, readReady}, 32'h1);
         if (e == 17) begin
            check("t5_accepted", {31'h0, readReady}, 32'h0);
            readValid = 1'b0;
         end
      end
      ncs = 1'b1;
      frame(16, 1'b0);
      repeat (2) @(negedge spiClk);
      #1;
      check("t5_done_pulses", doneCount - d0, 3);

      // Asynchronous reset in the middle of a frame
      push(12'h9C3);
      @(negedge spiClk);
      #1;
      ncs = 1'b0;
      repeat (9) @(negedge spiClk);
      @(posedge spiClk);
      #2;
      reset = 1'b1;
      #1;
      check("t6_readReady", {31'h0, readReady}, 32'h1);
      check("t6_frameDone", {31'h0, frameDone}, 32'h0);
      check("t6_sdo", {31'h0, sdo}, 32'h0);
      check("t6_sdoEnable", {31'h0, sdoEnable}, 32'h1);
      check("t6_state", {30'h0, dut.state}, {30'h0, WAITING});
      ncs = 1'b1;
      @(negedge spiClk);
      @(posedge spiClk);
      #1;
      reset = 1'b0;
      expQ.push_back(16'h0000);
      frame(16, 1'b0);
      #1;
      check("t6_underrun", {31'h0, underrun}, 32'h1);

      repeat (3) @(negedge spiClk);
      check("queue_drained", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
